// File: rtl/alu_op_sequencer_if.sv
// Handshake and bus bundle between ALU client, sequencer and serial core.
// slave is the sequencer's view; master is the client/core side.
interface alu_op_sequencer_if #(
   parameter int DATA_W = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [1:0]            in_op;
   logic [DATA_W-1:0]     in_x;
   logic [DATA_W-1:0]     in_y;
   logic                  core_begin;
   logic [1:0]            core_op;
   logic [DATA_W-1:0]     core_inbus;
   logic                  core_end_op;
   logic [2*DATA_W-1:0]   core_result;
   logic                  res_valid;
   logic                  res_ready;
   logic [2*DATA_W-1:0]   res_data;
   logic                  res_err;

   modport slave (
      input  in_valid, in_op, in_x, in_y,
      input  core_end_op, core_result, res_ready,
      output in_ready, core_begin, core_op, core_inbus,
      output res_valid, res_data, res_err
   );

   modport master (
      output in_valid, in_op, in_x, in_y,
      output core_end_op, core_result, res_ready,
      input  in_ready, core_begin, core_op, core_inbus,
      input  res_valid, res_data, res_err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one operand pair to the serial arithmetic core and returns
// its result (or a timeout error) through a valid/ready handshake.
module alu_op_sequencer #(
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_W          = 8
) (
   input  logic             clk,
   input  logic             rst_b,
   alu_op_sequencer_if.slave bus,
   output logic             busy,
   output logic [CNT_W-1:0] op_count
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] CNT_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND_X,
      S_SEND_Y,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   x_q, x_d;
   logic [DATA_W-1:0]   y_q, y_d;
   logic [1:0]          op_q, op_d;
   logic [2*DATA_W-1:0] res_q, res_d;
   logic                err_q, err_d;
   logic [TW-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]    count_q, count_d;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         x_q     <= '0;
         y_q     <= '0;
         op_q    <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         op_q    <= op_d;
         res_q   <= res_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      op_d    = op_q;
      res_d   = res_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               x_d     = bus.in_x;
               y_d     = bus.in_y;
               op_d    = bus.in_op;
               err_d   = 1'b0;
               state_d = S_SEND_X;
            end
         end
         S_SEND_X: state_d = S_SEND_Y;
         S_SEND_Y: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // a completion on the last allowed cycle beats the timeout
            if (bus.core_end_op) begin
               res_d   = bus.core_result;
               err_d   = 1'b0;
               state_d = S_HOLD;
            end else if (cnt_q == CNT_MAX) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_HOLD: begin
            if (bus.res_ready) begin
               count_d = count_q + 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.core_inbus = '0;
      if (state_q == S_SEND_X) bus.core_inbus = x_q;
      if (state_q == S_SEND_Y) bus.core_inbus = y_q;
   end

   assign bus.in_ready   = (state_q == S_IDLE);
   assign bus.core_begin = (state_q == S_SEND_X);
   assign bus.core_op    = op_q;
   assign bus.res_valid  = (state_q == S_HOLD);
   assign bus.res_data   = res_q;
   assign bus.res_err    = err_q;
   assign busy           = (state_q != S_IDLE);
   assign op_count       = count_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed table, corner sequences and
// randomized operations against a timing/result reference model.
module tb_alu_op_sequencer;
   localparam int TO = 8;

   logic       clk;
   logic       rst_b;
   logic       busy;
   logic [1:0] op_count;

   alu_op_sequencer_if #(.DATA_W(8)) bus ();

   alu_op_sequencer #(
      .DATA_W(8),
      .TIMEOUT_CYCLES(TO),
      .CNT_W(2)
   ) dut (
      .clk(clk),
      .rst_b(rst_b),
      .bus(bus),
      .busy(busy),
      .op_count(op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int errors  = 0;

   int          stub_delay = 0;
   logic [15:0] stub_res   = '0;
   logic        inj_end    = 1'b0;
   int          cd;

   // core stub: end_op `stub_delay` cycles after the begin cycle
   initial begin
      cd = 0;
      forever begin
         @(posedge clk);
         #2;
         bus.core_end_op = inj_end;
         if (!rst_b) cd = 0;
         else if (cd > 0) begin
            cd--;
            if (cd == 0) bus.core_end_op = 1'b1;
         end
         if (bus.core_end_op) bus.core_result = stub_res;
         else bus.core_result = 16'($urandom);
         if (rst_b && bus.core_begin && stub_delay > 0) cd = stub_delay;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " in_ready"}, 32'(bus.in_ready), 1);
      chk({tag, " core_begin"}, 32'(bus.core_begin), 0);
      chk({tag, " core_op"}, 32'(bus.core_op), 0);
      chk({tag, " core_inbus"}, 32'(bus.core_inbus), 0);
      chk({tag, " res_valid"}, 32'(bus.res_valid), 0);
      chk({tag, " res_data"}, 32'(bus.res_data), 0);
      chk({tag, " res_err"}, 32'(bus.res_err), 0);
      chk({tag, " busy"}, 32'(busy), 0);
      chk({tag, " op_count"}, 32'(op_count), 0);
   endtask

   task automatic run_op(input string nm, input logic [7:0] x,
                         input logic [7:0] y, input logic [1:0] op,
                         input int d, input logic [15:0] res,
                         input int bp, input logic [15:0] ed,
                         input logic ee, input int lat, input int cnt);
      int g;
      int n;
      g = 0;
      while (!bus.in_ready && g < 50) begin
         tick();
         g++;
      end
      chk({nm, " ready"}, 32'(bus.in_ready), 1);
      bus.in_x     = x;
      bus.in_y     = y;
      bus.in_op    = op;
      bus.in_valid = 1'b1;
      stub_delay   = d;
      stub_res     = res;
      tick();
      bus.in_valid = 1'b0;
      chk({nm, " begin"}, 32'(bus.core_begin), 1);
      chk({nm, " inbus_x"}, 32'(bus.core_inbus), 32'(x));
      chk({nm, " core_op"}, 32'(bus.core_op), 32'(op));
      chk({nm, " busy_ready"}, {busy, bus.in_ready}, 32'b10);
      chk({nm, " err_clr"}, 32'(bus.res_err), 0);
      tick();
      chk({nm, " begin_off"}, 32'(bus.core_begin), 0);
      chk({nm, " inbus_y"}, 32'(bus.core_inbus), 32'(y));
      chk({nm, " op_held"}, 32'(bus.core_op), 32'(op));
      n = 1;
      while (!bus.res_valid && n < 40) begin
         tick();
         n++;
         if (!bus.res_valid) chk({nm, " inbus_w"}, 32'(bus.core_inbus), 0);
      end
      chk({nm, " latency"}, n, lat);
      chk({nm, " data"}, 32'(bus.res_data), 32'(ed));
      chk({nm, " err"}, 32'(bus.res_err), 32'(ee));
      bus.res_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_x      = ~x;
      for (int i = 0; i < bp; i++) begin
         tick();
         chk({nm, " bp_valid"}, 32'(bus.res_valid), 1);
         chk({nm, " bp_data"}, 32'(bus.res_data), 32'(ed));
         chk({nm, " bp_ready"}, 32'(bus.in_ready), 0);
      end
      bus.res_ready = 1'b1;
      tick();
      bus.res_ready = 1'b0;
      bus.in_valid  = 1'b0;
      chk({nm, " idle_ready"}, 32'(bus.in_ready), 1);
      chk({nm, " valid_drop"}, 32'(bus.res_valid), 0);
      chk({nm, " count"}, 32'(op_count), 32'(cnt));
      chk({nm, " data_keep"}, 32'(bus.res_data), 32'(ed));
   endtask

   // spec-level model: a completion landing inside the WAIT window wins
   function automatic void model(input int d, output int lat,
                                 output logic err);
      if (d >= 2 && d <= TO + 1) begin
         lat = d + 1;
         err = 1'b0;
      end else begin
         lat = TO + 2;
         err = 1'b1;
      end
   endfunction

   typedef struct {
      logic [7:0]  x;
      logic [7:0]  y;
      logic [1:0]  op;
      int          d;
      logic [15:0] res;
      int          bp;
      logic [15:0] ed;
      logic        ee;
      int          lat;
      int          cnt;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int          mcnt;
      int          lat;
      logic        err;
      logic [7:0]  rx;
      logic [7:0]  ry;
      logic [1:0]  rop;
      logic [15:0] rres;
      int          rd;

      tbl[0] = '{8'h05, 8'hFD, 2'd0, 4, 16'hFFF1, 0, 16'hFFF1, 1'b0, 5, 1};
      tbl[1] = '{8'h7F, 8'h80, 2'd1, 3, 16'h1234, 10, 16'h1234, 1'b0, 4, 2};
      tbl[2] = '{8'h11, 8'h22, 2'd2, 0, 16'hABCD, 2, 16'h0000, 1'b1, 10, 3};
      tbl[3] = '{8'h33, 8'h44, 2'd3, 9, 16'hBEEF, 1, 16'hBEEF, 1'b0, 10, 0};
      tbl[4] = '{8'h55, 8'h66, 2'd0, 1, 16'h5A5A, 0, 16'h0000, 1'b1, 10, 1};
      tbl[5] = '{8'h77, 8'h88, 2'd1, 10, 16'hC3C3, 3, 16'h0000, 1'b1, 10, 2};
      tbl[6] = '{8'h99, 8'hAA, 2'd2, 2, 16'h8001, 0, 16'h8001, 1'b0, 3, 3};

      rst_b         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_x      = '0;
      bus.in_y      = '0;
      bus.res_ready = 1'b0;
      repeat (3) tick();
      chk_reset_outputs("reset");
      @(negedge clk);
      rst_b = 1'b1;
      tick();

      inj_end  = 1'b1;
      stub_res = 16'hDEAD;
      tick();
      inj_end = 1'b0;
      tick();
      chk("idle_spur valid", 32'(bus.res_valid), 0);
      chk("idle_spur ready", 32'(bus.in_ready), 1);
      chk("idle_spur data", 32'(bus.res_data), 0);

      for (int i = 0; i < 7; i++)
         run_op($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].op,
                tbl[i].d, tbl[i].res, tbl[i].bp, tbl[i].ed, tbl[i].ee,
                tbl[i].lat, tbl[i].cnt);

      bus.in_x     = 8'h3C;
      bus.in_y     = 8'hC3;
      bus.in_op    = 2'd1;
      bus.in_valid = 1'b1;
      stub_delay   = 0;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      chk("mid_wait busy", 32'(busy), 1);
      #2;
      rst_b = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(negedge clk);
      rst_b = 1'b1;
      tick();

      mcnt = 0;
      run_op("post_rst", 8'h02, 8'h03, 2'd0, 5, 16'h0006, 1,
             16'h0006, 1'b0, 6, 1);
      mcnt = 1;

      for (int i = 0; i < 40; i++) begin
         rx   = 8'($urandom);
         ry   = 8'($urandom);
         rop  = 2'($urandom);
         rd   = $urandom_range(0, TO + 4);
         rres = (rop == 2'd0) ? 16'($signed(rx) * $signed(ry))
                              : 16'($urandom);
         model(rd, lat, err);
         mcnt = (mcnt + 1) % 4;
         run_op($sformatf("rnd%0d", i), rx, ry, rop, rd, rres,
                $urandom_range(0, 3), err ? 16'h0000 : rres, err,
                lat, mcnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
